// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit.
//   state_t    : sequencer states (IDLE, RUN, DONE)
//   NIB_W      : width of one adder slice
//   idx_width(): width of the nibble index for a given nibble count
package nibble_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_fa4.sv
// FullAdder_4Bit: 4-bit ripple-carry adder slice.
//   a, b : nibble operands
//   cin  : carry in
//   sum  : nibble sum
//   cout : carry out of bit 3
module FullAdder_4Bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  // Explicit ripple so the slice stays a chain of full adders.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-nibble add/subtract that reuses one 4-bit slice,
// least-significant nibble first, with a registered carry between nibbles.
//   clk, rst                 : clock, synchronous active-high reset
//   start_valid/start_ready  : command handshake (op_a, op_b, sub)
//   res_valid/res_ready      : result handshake (result, carry_out, overflow)
//   carry_out                : carry from top nibble (1 = no borrow when sub)
//   overflow                 : two's-complement signed overflow
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [NIB_W*NIBBLES-1:0] op_a,
  input  logic [NIB_W*NIBBLES-1:0] op_b,
  input  logic                     sub,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [NIB_W*NIBBLES-1:0] result,
  output logic                     carry_out,
  output logic                     overflow
);

  localparam int DATA_W = NIB_W * NIBBLES;
  localparam int IDX_W  = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic                carry_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   result_q;
  logic                carry_out_q;
  logic                overflow_q;

  logic [NIB_W-1:0]    a_nib;
  logic [NIB_W-1:0]    b_nib;
  logic [NIB_W-1:0]    sum_nib;
  logic                slice_cout;

  // Same-sign operands producing an opposite-sign sum.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Nibble operand mux: select the current nibble of A and effective B.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[i*NIB_W +: NIB_W];
        b_nib = b_q[i*NIB_W +: NIB_W];
      end
    end
  end

  FullAdder_4Bit u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (sum_nib),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_q     <= op_a;
            // Subtract as A + ~B + 1: invert B here, seed the carry with sub.
            b_q     <= op_b ^ {DATA_W{sub}};
            carry_q <= sub;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          // Result write-enable decode: only the current nibble is updated.
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
              result_q[i*NIB_W +: NIB_W] <= sum_nib;
            end
          end
          carry_q <= slice_cout;
          if (idx_q == LAST_IDX) begin
            carry_out_q <= slice_cout;
            overflow_q  <= signed_ovf(a_nib[NIB_W-1], b_nib[NIB_W-1],
                                      sum_nib[NIB_W-1]);
            idx_q       <= '0;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign result      = result_q;
  assign carry_out   = carry_out_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int n_tests = 0;
  int n_fail  = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .carry_out   (carry_out),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Issue one command, wait for the result, capture it and complete the
  // result handshake. lat counts rising edges from acceptance to res_valid.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, output logic [W-1:0] r,
                       output logic co, output logic ov,
                       output int lat, output bit to);
    int guard;
    to  = 1'b0;
    lat = 0;
    r   = '0;
    co  = 1'b0;
    ov  = 1'b0;
    @(negedge clk);
    guard = 0;
    while (!start_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!start_ready) begin
      to = 1'b1;
      return;
    end
    op_a = a;
    op_b = b;
    sub  = s;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    sub  = 1'b0;
    while (!res_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
    end
    if (!res_valid) begin
      to = 1'b1;
      return;
    end
    @(negedge clk);
    r  = result;
    co = carry_out;
    ov = overflow;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_valid = 1'b1;
    op_a = 16'h1234;
    op_b = 16'h4321;
    sub  = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start_valid = 1'b0;
    n_tests++;
    if (start_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_start_ready got %b want 1", start_ready);
    end
    n_tests++;
    if (res_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_res_valid got %b want 0", res_valid);
    end
    n_tests++;
    if (result !== 16'h0000) begin
      n_fail++; $display("FAIL reset_result got %h want 0000", result);
    end
    n_tests++;
    if (carry_out !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got c=%b v=%b want c=0 v=0", carry_out, overflow);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_accept got rdy=%b vld=%b want rdy=1 vld=0", start_ready, res_valid);
    end
  endtask

  task automatic check_op(input string name, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] exp_r, input logic exp_c,
                          input logic exp_v, input bit chk_lat);
    logic [W-1:0] r;
    logic co, ov;
    int lat;
    bit to;
    do_op(a, b, s, r, co, ov, lat, to);
    n_tests++;
    if (to) begin
      n_fail++; $display("FAIL %s timeout got no result want result", name);
      return;
    end
    if (r !== exp_r) begin
      n_fail++; $display("FAIL %s result got %h want %h", name, r, exp_r);
    end
    n_tests++;
    if (co !== exp_c || ov !== exp_v) begin
      n_fail++; $display("FAIL %s flags got c=%b v=%b want c=%b v=%b", name, co, ov, exp_c, exp_v);
    end
    if (chk_lat) begin
      n_tests++;
      if (lat != 4) begin
        n_fail++; $display("FAIL %s latency got %0d want 4", name, lat);
      end
    end
  endtask

  task automatic test_add();
    check_op("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
    check_op("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    check_op("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_sub();
    check_op("sub_0005_0007", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    check_op("sub_8000_0001", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    int guard;
    int lat;
    // First operation: 0x1111 + 0x2222 = 0x3333.
    @(negedge clk);
    op_a = 16'h1111;
    op_b = 16'h2222;
    sub  = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // New command offered while the first is still busy.
    op_a = 16'hAAAA;
    op_b = 16'h0101;
    guard = 0;
    while (!res_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (!res_valid) begin
      n_fail++; $display("FAIL bp_done timeout got vld=0 want vld=1");
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (result !== 16'h3333 || carry_out !== 1'b0 || overflow !== 1'b0 ||
          start_ready !== 1'b0 || res_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got r=%h c=%b v=%b rdy=%b vld=%b want r=3333 c=0 v=0 rdy=0 vld=1",
                 i, result, carry_out, overflow, start_ready, res_valid);
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release got vld=%b rdy=%b want vld=0 rdy=1", res_valid, start_ready);
    end
    // Pending command is accepted at the next edge.
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    start_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_tests++;
    if (result !== 16'hABAB || carry_out !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL bp_second got r=%h c=%b v=%b want r=abab c=0 v=0", result, carry_out, overflow);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    op_a = 16'h1234;
    op_b = 16'h1111;
    sub  = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Second RUN cycle: reset here.
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0 || result !== 16'h0000) begin
      n_fail++; $display("FAIL rst_mid got rdy=%b vld=%b r=%h want rdy=1 vld=0 r=0000", start_ready, res_valid, result);
    end
    @(negedge clk);
    rst = 1'b0;
    check_op("after_rst_00ff_0001", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int n_acc;
    int n_res;
    int acc_cyc[2];
    logic [W-1:0] res_seen[2];
    n_acc = 0;
    n_res = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    res_seen[0] = '0;
    res_seen[1] = '0;
    @(negedge clk);
    op_a = 16'h0F0F;
    op_b = 16'h0101;
    sub  = 1'b0;
    start_valid = 1'b1;
    res_ready = 1'b1;
    for (int c = 0; c < 40 && n_res < 2; c++) begin
      if (c > 0) @(negedge clk);
      if (n_acc == 1) begin
        op_a = 16'h2000;
        op_b = 16'h3000;
      end
      if (res_valid) begin
        res_seen[n_res] = result;
        n_res++;
      end
      if (start_ready && n_acc < 2) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end
    end
    start_valid = 1'b0;
    res_ready = 1'b0;
    n_tests++;
    if (n_acc != 2 || acc_cyc[1] - acc_cyc[0] != 6) begin
      n_fail++; $display("FAIL b2b_period got acc=%0d gap=%0d want acc=2 gap=6", n_acc, acc_cyc[1] - acc_cyc[0]);
    end
    n_tests++;
    if (n_res != 2 || res_seen[0] !== 16'h1010 || res_seen[1] !== 16'h5000) begin
      n_fail++; $display("FAIL b2b_results got n=%0d r0=%h r1=%h want n=2 r0=1010 r1=5000", n_res, res_seen[0], res_seen[1]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
